// File: rtl/vga_rx_monitor.sv
`default_nettype none
// =====================================================================
// Module   : vga_rx_monitor
// Purpose  : VGA sink that rebuilds pixel coordinates from sync edges,
//            checks line/frame/blank timing, tracks lock, sums frames.
// Revision : 1.0
// =====================================================================
module vga_rx_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_ce,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_de,
    output logic        locked,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [15:0] h_err_cnt,
    output logic [15:0] v_err_cnt,
    output logic [15:0] blank_err_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [11:0] C_H_TOTAL = 12'(H_TOTAL);
    localparam logic [9:0]  C_V_TOTAL = 10'(V_TOTAL);
    localparam logic [10:0] C_H_FIRST = 11'(H_START);
    localparam logic [10:0] C_H_LAST  = 11'(H_START + H_ACTIVE - 1);
    localparam logic [9:0]  C_V_FIRST = 10'(V_START);
    localparam logic [9:0]  C_V_LAST  = 10'(V_START + V_ACTIVE - 1);
    localparam logic [9:0]  C_X_OFS   = 10'(H_START);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCK1  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [9:0]  rx_x_q, rx_x_d;
    logic [9:0]  rx_y_q, rx_y_d;
    logic        rx_de_q, rx_de_d;
    logic        locked_q, locked_d;
    logic        frame_done_q, frame_done_d;
    logic [31:0] frame_sum_q, frame_sum_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] h_err_q, h_err_d;
    logic [15:0] v_err_q, v_err_d;
    logic [15:0] blank_err_q, blank_err_d;

    logic w_hs_fall;
    logic w_vs_fall;
    logic w_line_bad;
    logic w_frame_bad;
    logic w_check;
    logic w_active;

    always_comb begin
        hs_d         = hs_q;
        vs_d         = vs_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        state_d      = state_q;
        rx_x_d       = rx_x_q;
        rx_y_d       = rx_y_q;
        rx_de_d      = rx_de_q;
        locked_d     = locked_q;
        frame_done_d = 1'b0;
        frame_sum_d  = frame_sum_q;
        acc_d        = acc_q;
        h_err_d      = h_err_q;
        v_err_d      = v_err_q;
        blank_err_d  = blank_err_q;

        w_hs_fall   = hs_q & ~VGA_HS;
        w_vs_fall   = vs_q & ~VGA_VS;
        w_line_bad  = w_hs_fall && (({1'b0, h_cnt_q} + 12'd1) != C_H_TOTAL);
        w_frame_bad = w_vs_fall && (v_cnt_q != C_V_TOTAL);
        w_check     = (state_q == ST_LOCK1) || (state_q == ST_LOCKED);
        w_active    = 1'b0;

        if (pix_ce) begin
            hs_d = VGA_HS;
            vs_d = VGA_VS;

            if (w_hs_fall)
                h_cnt_d = '0;
            else if (h_cnt_q != 11'h7FF)
                h_cnt_d = h_cnt_q + 11'd1;

            // VS restarts the line count even when HS falls on the same pixel
            if (w_vs_fall)
                v_cnt_d = '0;
            else if (w_hs_fall && (v_cnt_q != 10'h3FF))
                v_cnt_d = v_cnt_q + 10'd1;

            w_active = (h_cnt_d >= C_H_FIRST) && (h_cnt_d <= C_H_LAST) &&
                       (v_cnt_d >= C_V_FIRST) && (v_cnt_d <= C_V_LAST);

            rx_x_d  = h_cnt_d[9:0] - C_X_OFS;
            rx_y_d  = v_cnt_d - C_V_FIRST;
            rx_de_d = w_active && locked_q;

            if (w_check) begin
                if (w_line_bad && (h_err_q != 16'hFFFF))
                    h_err_d = h_err_q + 16'd1;
                if (w_frame_bad && (v_err_q != 16'hFFFF))
                    v_err_d = v_err_q + 16'd1;
                if ((VGA_BLANK_N != w_active) && (blank_err_q != 16'hFFFF))
                    blank_err_d = blank_err_q + 16'd1;
            end

            if (w_vs_fall) begin
                frame_sum_d  = acc_q;
                acc_d        = '0;
                frame_done_d = 1'b1;
            end else if (w_active && VGA_BLANK_N) begin
                acc_d = acc_q + {8'h00, VGA_R, VGA_G, VGA_B};
            end

            case (state_q)
                ST_SEARCH: begin
                    if (w_vs_fall)
                        state_d = ST_LOCK1;
                end
                ST_LOCK1: begin
                    if (w_line_bad)
                        state_d = ST_SEARCH;
                    else if (w_vs_fall)
                        state_d = w_frame_bad ? ST_LOCK1 : ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (w_line_bad || w_frame_bad)
                        state_d = ST_SEARCH;
                end
                default: state_d = ST_SEARCH;
            endcase

            locked_d = (state_d == ST_LOCKED);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_SEARCH;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            rx_x_q       <= '0;
            rx_y_q       <= '0;
            rx_de_q      <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_sum_q  <= '0;
            acc_q        <= '0;
            h_err_q      <= '0;
            v_err_q      <= '0;
            blank_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            rx_x_q       <= rx_x_d;
            rx_y_q       <= rx_y_d;
            rx_de_q      <= rx_de_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            frame_sum_q  <= frame_sum_d;
            acc_q        <= acc_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
            blank_err_q  <= blank_err_d;
        end
    end

    assign rx_x          = rx_x_q;
    assign rx_y          = rx_y_q;
    assign rx_de         = rx_de_q;
    assign locked        = locked_q;
    assign frame_done    = frame_done_q;
    assign frame_sum     = frame_sum_q;
    assign h_err_cnt     = h_err_q;
    assign v_err_cnt     = v_err_q;
    assign blank_err_cnt = blank_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
// =====================================================================
// Module   : tb_vga_rx_monitor
// Purpose  : Directed bench for vga_rx_monitor on a reduced raster.
// Revision : 1.0
// =====================================================================
module tb_vga_rx_monitor;

    // Reduced raster: 16 pixels x 12 lines, 8x6 active, H_START=6, V_START=4
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSY + HBP;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_ce;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic        rx_de;
    logic        locked;
    logic        frame_done;
    logic [31:0] frame_sum;
    logic [15:0] h_err_cnt;
    logic [15:0] v_err_cnt;
    logic [15:0] blank_err_cnt;

    int n_vec = 0;
    int n_err = 0;
    int de_cnt = 0;
    int fd_cnt = 0;
    int fd_long = 0;
    logic [9:0] first_x, first_y, last_x, last_y;

    vga_rx_monitor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) u_dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .pix_ce        (pix_ce),
        .VGA_HS        (VGA_HS),
        .VGA_VS        (VGA_VS),
        .VGA_BLANK_N   (VGA_BLANK_N),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .rx_x          (rx_x),
        .rx_y          (rx_y),
        .rx_de         (rx_de),
        .locked        (locked),
        .frame_done    (frame_done),
        .frame_sum     (frame_sum),
        .h_err_cnt     (h_err_cnt),
        .v_err_cnt     (v_err_cnt),
        .blank_err_cnt (blank_err_cnt)
    );

    always #10 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_locked"}, 32'(locked), 32'd0);
        check_eq({pfx, "_rx_de"}, 32'(rx_de), 32'd0);
        check_eq({pfx, "_rx_x"}, 32'(rx_x), 32'd0);
        check_eq({pfx, "_rx_y"}, 32'(rx_y), 32'd0);
        check_eq({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({pfx, "_frame_sum"}, frame_sum, 32'd0);
        check_eq({pfx, "_h_err"}, 32'(h_err_cnt), 32'd0);
        check_eq({pfx, "_v_err"}, 32'(v_err_cnt), 32'd0);
        check_eq({pfx, "_blank_err"}, 32'(blank_err_cnt), 32'd0);
    endtask

    // One pixel: pix_ce for one Clk, then one idle Clk; observe 1 ns after each edge
    task automatic pix(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        VGA_HS      = hs;
        VGA_VS      = vs;
        VGA_BLANK_N = bl;
        {VGA_R, VGA_G, VGA_B} = rgb;
        pix_ce = 1'b1;
        @(posedge Clk);
        #1;
        pix_ce = 1'b0;
        if (rx_de) begin
            de_cnt++;
            if (de_cnt == 1) begin
                first_x = rx_x;
                first_y = rx_y;
            end
            last_x = rx_x;
            last_y = rx_y;
        end
        if (frame_done) fd_cnt++;
        @(posedge Clk);
        #1;
        if (frame_done) fd_long++;
    endtask

    // Raster rows lo..hi; HS/VS placed like a counter-driven VGA controller
    task automatic gen(input int lo, input int hi, input int skip_row, input int short_row,
                       input int blank_row, input int blank_n, input logic [23:0] rgb);
        logic hs, vs, bl;
        for (int row = lo; row <= hi; row++) begin
            if (row == skip_row) continue;
            for (int hc = 0; hc < HT; hc++) begin
                if (row == short_row && hc == HT - 1) continue;
                hs = !(hc >= HA + HFP && hc < HA + HFP + HSY);
                vs = !(row >= VA + VFP && row < VA + VFP + VSY);
                bl = (hc < HA) && (row < VA);
                if (row == blank_row && hc >= 2 && hc < 2 + blank_n) bl = 1'b0;
                pix(hs, vs, bl, bl ? rgb : 24'h0);
            end
        end
    endtask

    initial begin
        Reset_n     = 1'b1;
        pix_ce      = 1'b0;
        VGA_HS      = 1'b1;
        VGA_VS      = 1'b1;
        VGA_BLANK_N = 1'b0;
        {VGA_R, VGA_G, VGA_B} = 24'h0;
        #3 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset");
        Reset_n = 1'b1;

        // Activity on every input but no pixel strobe
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            VGA_HS      = i[0];
            VGA_VS      = i[1];
            VGA_BLANK_N = i[2];
            {VGA_R, VGA_G, VGA_B} = 24'h123456 ^ 24'(i);
        end
        check_zero("noce");

        // Acquisition: first VS fall -> LOCK1, second clean VS fall -> LOCKED
        gen(0, 11, -1, -1, -1, 0, 24'h0A0B0C);
        check_eq("lock_after_1vs", 32'(locked), 32'd0);
        gen(0, 7, -1, -1, -1, 0, 24'h0A0B0C);
        check_eq("lock_before_2vs", 32'(locked), 32'd0);
        gen(8, 8, -1, -1, -1, 0, 24'h0A0B0C);
        check_eq("lock_after_2vs", 32'(locked), 32'd1);
        gen(9, 11, -1, -1, -1, 0, 24'h0A0B0C);
        check_eq("de_while_unlocked", 32'(de_cnt), 32'd0);
        fd_cnt = 0;

        // Clean locked frame: coordinates and checksum
        gen(0, 11, -1, -1, -1, 0, 24'h010203);
        check_eq("de_count", 32'(de_cnt), 32'd48);
        check_eq("first_x", 32'(first_x), 32'd0);
        check_eq("first_y", 32'(first_y), 32'd0);
        check_eq("last_x", 32'(last_x), 32'd7);
        check_eq("last_y", 32'(last_y), 32'd5);
        check_eq("sum_010203", frame_sum, 32'h0030_6090);
        check_eq("ideal_h_err", 32'(h_err_cnt), 32'd0);
        check_eq("ideal_v_err", 32'(v_err_cnt), 32'd0);
        check_eq("ideal_blank_err", 32'(blank_err_cnt), 32'd0);

        // Constant red 0x01: 48 * 0x010000
        gen(0, 11, -1, -1, -1, 0, 24'h010000);
        check_eq("sum_red1", frame_sum, 32'h0030_0000);

        // BLANK_N low for 4 active pixels of line 2: 44 pixels summed
        gen(0, 11, -1, -1, 2, 4, 24'h000001);
        check_eq("blank_err_4", 32'(blank_err_cnt), 32'd4);
        check_eq("blank_keeps_lock", 32'(locked), 32'd1);
        check_eq("sum_blanked", frame_sum, 32'h0000_002C);
        check_eq("frame_done_count", 32'(fd_cnt), 32'd3);

        // Line 3 one pixel short: detected at line 4 HS fall; the slipped
        // line 4 also shows 2 blank mismatches before lock drops
        gen(0, 3, -1, 3, -1, 0, 24'h00FF00);
        check_eq("short_pending_lock", 32'(locked), 32'd1);
        check_eq("short_pending_h_err", 32'(h_err_cnt), 32'd0);
        gen(4, 4, -1, -1, -1, 0, 24'h00FF00);
        check_eq("short_h_err", 32'(h_err_cnt), 32'd1);
        check_eq("short_lock_drop", 32'(locked), 32'd0);
        check_eq("short_blank_err", 32'(blank_err_cnt), 32'd6);
        gen(5, 11, -1, -1, -1, 0, 24'h00FF00);
        check_eq("relock_1vs", 32'(locked), 32'd0);
        gen(0, 11, -1, -1, -1, 0, 24'h00FF00);
        check_eq("relock_2vs", 32'(locked), 32'd1);

        // 11-line frame: line 10 dropped, caught at the following VS fall
        gen(0, 11, 10, -1, -1, 0, 24'h000100);
        gen(0, 7, -1, -1, -1, 0, 24'h000100);
        check_eq("vshort_pending_lock", 32'(locked), 32'd1);
        check_eq("vshort_pending_v_err", 32'(v_err_cnt), 32'd0);
        check_eq("vshort_blank_err", 32'(blank_err_cnt), 32'd22);
        gen(8, 8, -1, -1, -1, 0, 24'h000100);
        check_eq("vshort_v_err", 32'(v_err_cnt), 32'd1);
        check_eq("vshort_lock_drop", 32'(locked), 32'd0);
        check_eq("vshort_h_err_same", 32'(h_err_cnt), 32'd1);
        gen(9, 11, -1, -1, -1, 0, 24'h000100);

        // Relock, then asynchronous reset in the middle of a frame
        gen(0, 11, -1, -1, -1, 0, 24'h000100);
        gen(0, 11, -1, -1, -1, 0, 24'h000100);
        check_eq("pre_reset_lock", 32'(locked), 32'd1);
        gen(0, 3, -1, -1, -1, 0, 24'h000100);
        #4 Reset_n = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        gen(4, 11, -1, -1, -1, 0, 24'h000100);
        check_eq("rst_lock_1vs", 32'(locked), 32'd0);
        gen(0, 7, -1, -1, -1, 0, 24'h000100);
        check_eq("rst_lock_pre_2vs", 32'(locked), 32'd0);
        gen(8, 8, -1, -1, -1, 0, 24'h000100);
        check_eq("rst_lock_2vs", 32'(locked), 32'd1);
        check_eq("rst_h_err", 32'(h_err_cnt), 32'd0);
        check_eq("rst_v_err", 32'(v_err_cnt), 32'd0);
        check_eq("rst_blank_err", 32'(blank_err_cnt), 32'd0);
        check_eq("frame_done_width", 32'(fd_long), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
VGA sink/checker: the receiving end of the VGA_controller/color_mapper output interface. Samples VGA_HS/VGA_VS/VGA_BLANK_N/VGA_R/G/B on a pixel strobe and rebuilds the pixel coordinates from the sync edges. Checks line, frame and blanking timing against the 640x480 parameters, keeps a lock state machine, and reports a per-frame pixel checksum. It sits beside the toplevel in simulation and in on-chip debug builds, so frame content and timing can be checked without a monitor.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, HS low width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS low width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous, active-low reset
pix_ce  in  1  one-Clk pulse per pixel (25 MHz rate); all sampling is qualified by it
VGA_HS  in  1  horizontal sync, active low
VGA_VS  in  1  vertical sync, active low
VGA_BLANK_N  in  1  high during active video
VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
rx_x  out  10  reconstructed X of the current active pixel
rx_y  out  10  reconstructed Y of the current active pixel
rx_de  out  1  rx_x/rx_y/colour valid (expected-active pixel)
locked  out  1  timing lock achieved
frame_done  out  1  one-Clk pulse at each VS falling edge
frame_sum  out  32  checksum of the last completed frame
h_err_cnt  out  16  count of bad line lengths
v_err_cnt  out  16  count of bad frame lengths
blank_err_cnt  out  16  count of BLANK_N/active-region mismatches

Behaviour:
- Derived values: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800. V_TOTAL=525. H_START=H_SYNC+H_BP=144. V_START=V_SYNC+V_BP=35.
- Reset (async, Reset_n=0): all counters, outputs and the state register go to 0. State=SEARCH.
- No register changes on a Clk cycle with pix_ce=0, except that frame_done returns to 0.
- Edge detect: hs_q and vs_q are updated on pix_ce. An HS fall is hs_q=1 and VGA_HS=0 on a pix_ce; VS fall is defined the same way.
- h_cnt (11 bit):
  - On an HS fall, the line length is h_cnt+1. h_cnt then loads 0.
  - Otherwise h_cnt increments and saturates at 2047.
- v_cnt (10 bit):
  - On a VS fall, the frame length is v_cnt. v_cnt then loads 0.
  - Otherwise v_cnt increments on each HS fall and saturates at 1023.
  - When VS and HS fall on the same pix_ce, the VS handling takes priority and v_cnt=0.
- Active region: h_cnt in [H_START, H_START+H_ACTIVE-1] and v_cnt in [V_START, V_START+V_ACTIVE-1].
- rx_de, rx_x=h_cnt-H_START and rx_y=v_cnt-V_START are registered 1 Clk after the sampling pix_ce. rx_de=0 unless locked=1.
- Checks apply only in the LOCK1 and LOCKED states; all error counters saturate at 0xFFFF.
  - Line error: an HS fall with line length != H_TOTAL increments h_err_cnt.
  - Frame error: a VS fall with v_cnt != V_TOTAL increments v_err_cnt.
  - Blank error: a pix_ce where VGA_BLANK_N != active-region increments blank_err_cnt by 1 per pixel.
- Checksum:
  - An accumulator adds {8'h00,R,G,B} (mod 2^32) on every pix_ce in the active region with VGA_BLANK_N=1.
  - On a VS fall, frame_sum takes the accumulator value, the accumulator clears, and frame_done pulses for 1 Clk.
  - frame_sum and frame_done are updated in every state.
- State machine (transitions evaluated on pix_ce):
  - SEARCH: wait for a VS fall, then go to LOCK1. Errors are not counted.
  - LOCK1: on a VS fall, go to LOCKED if no line or frame error occurred since entry, else go back to LOCK1. An HS line error goes to SEARCH.
  - LOCKED: any line or frame error goes to SEARCH. Blank errors are counted but do not drop lock.
  - locked=1 only in LOCKED. It rises on the Clk after the second clean VS fall.
- Reset mid-frame: everything clears; the next VS fall restarts acquisition.

Test Plan:
- Ideal 640x480 stream, 3 frames -> locked=1 after the 2nd VS fall. Error counts stay 0. rx_de is high for exactly 307200 pix_ce per frame; the first is at rx_x=0, rx_y=0 and the last at rx_x=639, rx_y=479.
- Locked, then one line shortened to 799 pixels -> h_err_cnt=1 and locked=0 on that HS fall. locked=1 again 2 clean frames later.
- Constant colour R=0x01, G=B=0x00 for one locked frame -> frame_sum=0xB0000000 with a one-Clk frame_done.
- Locked, BLANK_N held low for 4 active pixels of one line -> blank_err_cnt=4 and locked stays 1.
- Frame of 524 lines while locked -> v_err_cnt=1 and locked=0. Stream with pix_ce=0 throughout -> all outputs remain 0.
- Reset_n pulsed low mid-frame (asynchronous, between Clk edges) -> all outputs are 0 immediately. locked=1 after 2 further VS falls.
